cd_uart_tick_gen: RTL and testbench



---
 rtl/cd_uart_tick_gen.sv | 122 ++++++++++++
 tb/tb_cd_uart_tick_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_uart_tick_gen.sv
// rtl/cd_uart_tick_gen.sv - oversample/bit tick generator with deferred baud reload
// Optional mid-bit tick is built only when CD_TICK_MIDBIT_EN is defined.
module cd_uart_tick_gen #(
    parameter int WIDTH_UART_CLK_LIMIT = 16,
    parameter int OVERSAMPLE           = 16,
    parameter int WIDTH_OS_CNT         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH_UART_CLK_LIMIT-1:0] baudrate,
    input  logic                            c_UART_ready,
    input  logic                            enable,
    input  logic                            uart_busy,
    output logic                            tick_os,
    output logic                            tick_bit,
    output logic                            tick_mid,
    output logic                            locked,
    output logic                            reload_pending
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        PEND = 2'd3
    } state_t;

    localparam logic [WIDTH_OS_CNT-1:0]         OS_LAST  = WIDTH_OS_CNT'(OVERSAMPLE - 1);
    localparam logic [WIDTH_OS_CNT-1:0]         OS_ONE   = WIDTH_OS_CNT'(1);
    localparam logic [WIDTH_UART_CLK_LIMIT-1:0] DIV_ONE  = WIDTH_UART_CLK_LIMIT'(1);

    state_t                          state;
    state_t                          state_nxt;
    logic [WIDTH_UART_CLK_LIMIT-1:0] div_cnt;
    logic [WIDTH_UART_CLK_LIMIT-1:0] limit_reg;
    logic [WIDTH_OS_CNT-1:0]         os_cnt;
    logic                            counting;
    logic                            div_wrap;
    logic                            bit_start;

    // PEND keeps the old timebase alive until the frame can be cut at a bit edge.
    assign counting  = (state == RUN) || (state == PEND);
    assign div_wrap  = (div_cnt == limit_reg);
    assign bit_start = (os_cnt == '0) && (div_cnt == '0);

    assign tick_os  = counting && div_wrap;
    assign tick_bit = tick_os && (os_cnt == OS_LAST);
    assign locked   = (state != LOAD);

`ifdef CD_TICK_MIDBIT_EN
    localparam logic [WIDTH_OS_CNT-1:0] OS_MID = WIDTH_OS_CNT'(OVERSAMPLE / 2 - 1);
    assign tick_mid = tick_os && (os_cnt == OS_MID);
`else
    assign tick_mid = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (!c_UART_ready) begin
                    state_nxt = LOAD;
                end else if (enable) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = HOLD;
                end
            end
            RUN: begin
                if (!c_UART_ready) begin
                    state_nxt = uart_busy ? PEND : LOAD;
                end else if (!enable) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!c_UART_ready) begin
                    state_nxt = uart_busy ? PEND : LOAD;
                end else if (enable) begin
                    state_nxt = RUN;
                end
            end
            PEND: begin
                if (!uart_busy && (tick_bit || bit_start)) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LOAD;
            div_cnt        <= '0;
            os_cnt         <= '0;
            limit_reg      <= '0;
            reload_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                limit_reg      <= baudrate;
                div_cnt        <= '0;
                os_cnt         <= '0;
                reload_pending <= 1'b0;
            end else begin
                if (!c_UART_ready) begin
                    reload_pending <= 1'b1;
                end
                if (counting) begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cd_uart_tick_gen.sv
// tb/tb_cd_uart_tick_gen.sv - directed self-checking bench for cd_uart_tick_gen
module tb_cd_uart_tick_gen;

`ifdef CD_TICK_MIDBIT_EN
    localparam bit MID_EN = 1'b1;
`else
    localparam bit MID_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baudrate = 16'd3;
    logic        c_UART_ready = 1'b1;
    logic        enable = 1'b1;
    logic        uart_busy = 1'b0;
    logic        tick_os;
    logic        tick_bit;
    logic        tick_mid;
    logic        locked;
    logic        reload_pending;

    int errors = 0;
    int checks = 0;

    logic [3:0] got;
    logic [3:0] exp;

    cd_uart_tick_gen dut (
        .clk            (clk),
        .rst            (rst),
        .baudrate       (baudrate),
        .c_UART_ready   (c_UART_ready),
        .enable         (enable),
        .uart_busy      (uart_busy),
        .tick_os        (tick_os),
        .tick_bit       (tick_bit),
        .tick_mid       (tick_mid),
        .locked         (locked),
        .reload_pending (reload_pending)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in the LOAD cycle that follows reset release (cycle k=0).
    task automatic do_reset(input logic [15:0] b);
        rst = 1'b1;
        baudrate = b;
        c_UART_ready = 1'b1;
        uart_busy = 1'b0;
        enable = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        baudrate = 16'd3;
        enable = 1'b1;
        step();
        step();
        #1;
        got = {tick_os, tick_bit, tick_mid, locked};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000", got);
        end
        checks++;
        if (reload_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending got=%b exp=0", reload_pending);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_locked got=%b exp=0", locked);
        end
    endtask

    task automatic test_basic();
        do_reset(16'd3);
        for (int k = 0; k < 200; k++) begin
            if (k > 0) step();
            #1;
            got = {tick_os, tick_bit, tick_mid, locked};
            exp = {(k > 0) && (k % 4 == 0), (k > 0) && (k % 64 == 0),
                   MID_EN && (k % 64 == 32), k > 0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_ticks k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_baud_zero();
        do_reset(16'd0);
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step();
            #1;
            got = {tick_os, tick_bit, tick_mid, locked};
            exp = {k > 0, (k > 0) && (k % 16 == 0), MID_EN && (k % 16 == 8), k > 0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL baud0_ticks k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_reload_idle();
        do_reset(16'd3);
        for (int k = 1; k <= 20; k++) step();
        step();
        baudrate = 16'd7;
        c_UART_ready = 1'b0;
        #1;
        checks++;
        if ({tick_os, reload_pending} !== 2'b00) begin
            errors++;
            $display("FAIL idle_pulse_cycle got=%b exp=00", {tick_os, reload_pending});
        end
        step();
        c_UART_ready = 1'b1;
        #1;
        checks++;
        if ({reload_pending, locked, tick_os} !== 3'b100) begin
            errors++;
            $display("FAIL idle_load_cycle got=%b exp=100", {reload_pending, locked, tick_os});
        end
        for (int j = 1; j < 260; j++) begin
            step();
            #1;
            got = {tick_os, tick_bit, tick_mid, locked};
            exp = {j % 8 == 0, j % 128 == 0, MID_EN && (j % 128 == 64), 1'b1};
            checks++;
            if (got !== exp || reload_pending !== 1'b0) begin
                errors++;
                $display("FAIL idle_new_period j=%0d got=%b/%b exp=%b/0",
                         j, got, reload_pending, exp);
            end
        end
    endtask

    task automatic test_reload_busy();
        do_reset(16'd3);
        for (int k = 1; k <= 10; k++) step();
        step();
        baudrate = 16'd7;
        c_UART_ready = 1'b0;
        uart_busy = 1'b1;
        for (int k = 12; k <= 129 + 140; k++) begin
            logic exp_pend;
            int   j;
            step();
            c_UART_ready = 1'b1;
            if (k == 70) uart_busy = 1'b0;
            #1;
            if (k <= 128) begin
                exp = {k % 4 == 0, (k == 64) || (k == 128), MID_EN && (k % 64 == 32), 1'b1};
                exp_pend = 1'b1;
            end else if (k == 129) begin
                exp = 4'b0000;
                exp_pend = 1'b1;
            end else begin
                j = k - 129;
                exp = {j % 8 == 0, j % 128 == 0, MID_EN && (j % 128 == 64), 1'b1};
                exp_pend = 1'b0;
            end
            got = {tick_os, tick_bit, tick_mid, locked};
            checks++;
            if (got !== exp || reload_pending !== exp_pend) begin
                errors++;
                $display("FAIL busy_deferred k=%0d got=%b/%b exp=%b/%b",
                         k, got, reload_pending, exp, exp_pend);
            end
        end
    endtask

    task automatic test_enable_hold();
        int e;
        do_reset(16'd3);
        for (int k = 1; k <= 300; k++) begin
            step();
            enable = !(k >= 22 && k <= 31);
            #1;
            if (k <= 22) e = k;
            else if (k <= 32) e = -1;
            else e = k - 10;
            if (e < 0) exp = 4'b0001;
            else exp = {e % 4 == 0, e % 64 == 0, MID_EN && (e % 64 == 32), 1'b1};
            got = {tick_os, tick_bit, tick_mid, locked};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL enable_hold k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset(16'd3);
        c_UART_ready = 1'b0;
        baudrate = 16'd5;
        #1;
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_load got=%b exp=0", locked);
        end
        step();
        c_UART_ready = 1'b1;
        #1;
        checks++;
        if ({tick_os, locked} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_reload got=%b exp=00", {tick_os, locked});
        end
        for (int j = 1; j <= 40; j++) begin
            step();
            #1;
            checks++;
            if ({tick_os, locked} !== {j % 6 == 0, 1'b1}) begin
                errors++;
                $display("FAIL b2b_period j=%0d got=%b exp=%b",
                         j, {tick_os, locked}, {j % 6 == 0, 1'b1});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(16'd3);
        for (int k = 1; k <= 10; k++) step();
        step();
        baudrate = 16'd7;
        c_UART_ready = 1'b0;
        uart_busy = 1'b1;
        step();
        c_UART_ready = 1'b1;
        #1;
        checks++;
        if ({reload_pending, locked} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_pend got=%b exp=11", {reload_pending, locked});
        end
        rst = 1'b1;
        baudrate = 16'd3;
        step();
        rst = 1'b0;
        uart_busy = 1'b0;
        #1;
        checks++;
        if ({reload_pending, locked} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_cleared got=%b exp=00", {reload_pending, locked});
        end
        for (int j = 1; j <= 12; j++) begin
            step();
            #1;
            checks++;
            if (tick_os !== (j % 4 == 0)) begin
                errors++;
                $display("FAIL midrst_period j=%0d got=%b exp=%b", j, tick_os, j % 4 == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_baud_zero();
        test_reload_idle();
        test_reload_busy();
        test_enable_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
